// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - FP32 field constants, rounding modes, flag indices and round-increment helper
package fpu_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLG_NV  = 4;
  localparam int FLG_DZ  = 3;
  localparam int FLG_OF  = 2;
  localparam int FLG_UF  = 1;
  localparam int FLG_NX  = 0;
  localparam int FLAGS_W = 5;

  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 23;
  localparam int FP_BIAS  = 127;

  // tiny covers zero and subnormals; the stage-1 sticky then says which
  typedef struct packed {
    logic nan;
    logic inf;
    logic ovf;
    logic tiny;
  } fcls_t;

  function automatic logic round_inc(input logic [2:0] rm, input logic sign,
                                     input logic lsb, input logic g, input logic st);
    logic inc;
    case (rm)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | st);
      RM_RUP:  inc = ~sign & (g | st);
      RM_RMM:  inc = g;
      default: inc = g & (lsb | st);
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fcvt_int_pipe_if.sv
// rtl/fcvt_int_pipe_if.sv - issue-side and writeback-side handshake bundle of the converter
interface fcvt_int_pipe_if #(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
);
  import fpu_pkg::*;

  logic                              in_valid;
  logic                              in_ready;
  logic [FP_EXP_W+FP_MAN_W:0]        in_x;
  logic [2:0]                        in_rm;
  logic                              in_uns;
  logic [TAG_W-1:0]                  in_tag;
  logic                              out_valid;
  logic                              out_ready;
  logic [INT_W-1:0]                  out_y;
  logic [FLAGS_W-1:0]                out_flags;
  logic [TAG_W-1:0]                  out_tag;

  modport master (
    output in_valid, in_x, in_rm, in_uns, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_rm, in_uns, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_tag
  );

endinterface

// File: rtl/fcvt_round_sat.sv
// rtl/fcvt_round_sat.sv - stage 2: rounding increment, negation, range check and exception flags
module fcvt_round_sat
  import fpu_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic               sign_i,
  input  logic               uns_i,
  input  logic [2:0]         rm_i,
  input  logic [INT_W-1:0]   mag_i,
  input  logic               g_i,
  input  logic               st_i,
  input  fcls_t              cls_i,
  output logic [INT_W-1:0]   y_o,
  output logic [FLAGS_W-1:0] flags_o
);

  logic             inc;
  logic             inexact;
  logic             nv;
  logic             nx;
  logic [INT_W:0]   rmag;
  logic [INT_W:0]   neg;
  logic [INT_W-1:0] max_v;
  logic [INT_W-1:0] min_v;

  always_comb begin
    inc     = round_inc(rm_i, sign_i, mag_i[0], g_i, st_i);
    rmag    = {1'b0, mag_i} + {{INT_W{1'b0}}, inc};
    neg     = -rmag;
    inexact = g_i | st_i;
    max_v   = uns_i ? {INT_W{1'b1}} : {1'b0, {(INT_W-1){1'b1}}};
    min_v   = uns_i ? {INT_W{1'b0}} : {1'b1, {(INT_W-1){1'b0}}};
    y_o     = '0;
    nv      = 1'b0;
    nx      = 1'b0;
    if (cls_i.nan) begin
      y_o = max_v;
      nv  = 1'b1;
    end else if (cls_i.inf || cls_i.ovf) begin
      y_o = sign_i ? min_v : max_v;
      nv  = 1'b1;
    end else if (cls_i.tiny) begin
      nx = st_i;
    end else if (sign_i) begin
      // the wide negation lands in range only with its top two bits set
      if (rmag == '0) begin
        nx = inexact;
      end else if (!uns_i && (neg[INT_W:INT_W-1] == 2'b11)) begin
        y_o = neg[INT_W-1:0];
        nx  = inexact;
      end else begin
        y_o = min_v;
        nv  = 1'b1;
      end
    end else if (uns_i ? rmag[INT_W] : (|rmag[INT_W:INT_W-1])) begin
      y_o = max_v;
      nv  = 1'b1;
    end else begin
      y_o = rmag[INT_W-1:0];
      nx  = inexact;
    end
    flags_o         = '0;
    flags_o[FLG_NV] = nv;
    flags_o[FLG_DZ] = 1'b0;
    flags_o[FLG_OF] = 1'b0;
    flags_o[FLG_UF] = 1'b0;
    flags_o[FLG_NX] = nx;
  end

endmodule

// File: rtl/fcvt_int_pipe.sv
// rtl/fcvt_int_pipe.sv - two-stage elastic FP32 to signed/unsigned integer converter
module fcvt_int_pipe
  import fpu_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int TAG_W = 5
) (
  input logic            clk,
  input logic            rstn,
  fcvt_int_pipe_if.slave io
);

  localparam int                   EXT_W    = INT_W + 26;
  localparam int                   SH_W     = 9;
  localparam logic [SH_W-1:0]      RSH_BASE = SH_W'(INT_W + FP_BIAS - 1);
  localparam logic [SH_W-1:0]      RSH_MAX  = SH_W'(EXT_W);
  localparam logic [FP_EXP_W-1:0]  EXP_OVF  = FP_EXP_W'(FP_BIAS + INT_W);

  logic                s1_valid_q, s1_valid_d;
  logic                s1_sign_q, s1_uns_q, s1_g_q, s1_st_q;
  logic                s1_g_d, s1_st_d;
  logic [2:0]          s1_rm_q;
  logic [INT_W-1:0]    s1_mag_q, s1_mag_d;
  fcls_t               s1_cls_q, s1_cls_d;
  logic [TAG_W-1:0]    s1_tag_q;
  logic                out_valid_q, out_valid_d;
  logic [INT_W-1:0]    out_y_q;
  logic [FLAGS_W-1:0]  out_flags_q;
  logic [TAG_W-1:0]    out_tag_q;

  logic                adv, in_fire, out_load;
  logic [FP_EXP_W-1:0] dec_exp;
  logic [FP_MAN_W-1:0] dec_man;
  logic [SH_W-1:0]     rsh;
  logic [2*EXT_W-1:0]  shifted;
  logic [INT_W-1:0]    rs_y;
  logic [FLAGS_W-1:0]  rs_flags;

  assign adv          = !out_valid_q || io.out_ready;
  assign io.in_ready  = !s1_valid_q || adv;
  assign in_fire      = io.in_valid && io.in_ready;
  assign out_load     = adv && s1_valid_q;
  assign s1_valid_d   = io.in_ready ? io.in_valid : s1_valid_q;
  assign out_valid_d  = adv ? s1_valid_q : out_valid_q;

  assign io.out_valid = out_valid_q;
  assign io.out_y     = out_y_q;
  assign io.out_flags = out_flags_q;
  assign io.out_tag   = out_tag_q;

  // Fixed point with INT_W integer bits over 26 fraction bits: guard at 25, sticky below,
  // everything shifted past the bottom lands in the lower half and folds into sticky.
  always_comb begin
    dec_exp       = io.in_x[FP_EXP_W+FP_MAN_W-1:FP_MAN_W];
    dec_man       = io.in_x[FP_MAN_W-1:0];
    s1_cls_d      = '0;
    s1_cls_d.nan  = (dec_exp == '1) && (dec_man != '0);
    s1_cls_d.inf  = (dec_exp == '1) && (dec_man == '0);
    s1_cls_d.ovf  = (dec_exp >= EXP_OVF) && (dec_exp != '1);
    s1_cls_d.tiny = (dec_exp == '0);
    if ({1'b0, dec_exp} > RSH_BASE) begin
      rsh = '0;
    end else begin
      rsh = RSH_BASE - {1'b0, dec_exp};
    end
    if (rsh > RSH_MAX) begin
      rsh = RSH_MAX;
    end
    shifted  = {1'b1, dec_man, {(INT_W+2){1'b0}}, {EXT_W{1'b0}}} >> rsh;
    s1_mag_d = shifted[2*EXT_W-1 -: INT_W];
    s1_g_d   = shifted[EXT_W+25];
    s1_st_d  = |shifted[EXT_W+24:0];
    if (s1_cls_d.tiny) begin
      s1_mag_d = '0;
      s1_g_d   = 1'b0;
      s1_st_d  = |dec_man;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (out_load) begin
        out_y_q     <= rs_y;
        out_flags_q <= rs_flags;
        out_tag_q   <= s1_tag_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sign_q <= io.in_x[FP_EXP_W+FP_MAN_W];
      s1_uns_q  <= io.in_uns;
      s1_rm_q   <= io.in_rm;
      s1_mag_q  <= s1_mag_d;
      s1_g_q    <= s1_g_d;
      s1_st_q   <= s1_st_d;
      s1_cls_q  <= s1_cls_d;
      s1_tag_q  <= io.in_tag;
    end
  end

  fcvt_round_sat #(.INT_W(INT_W)) u_round_sat (
    .sign_i  (s1_sign_q),
    .uns_i   (s1_uns_q),
    .rm_i    (s1_rm_q),
    .mag_i   (s1_mag_q),
    .g_i     (s1_g_q),
    .st_i    (s1_st_q),
    .cls_i   (s1_cls_q),
    .y_o     (rs_y),
    .flags_o (rs_flags)
  );

endmodule
